// File: rtl/jtag_scan_pkg.sv
// jtag_scan_pkg: shared state encoding, debug IR codes and default scan length for the scan master.
package jtag_scan_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SHIFT,
    S_UDR,
    S_RTI,
    S_DONE
  } state_t;
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;
  localparam int DEFAULT_DR_WIDTH = 38;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into tck while enabled and flags the clk edges where tck rises or falls.
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic term;
  assign term      = en && cnt == CW'(TCK_DIV - 1);
  assign rise_tick = term && !tck;
  assign fall_tick = term && tck;
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/jtag_debug_scan_master.sv
// jtag_debug_scan_master: scripts virtual-JTAG IR/DR scans into the Nios II debug module without a hub.
// Optional JTAG_SCAN_MASTER_IR_CACHE_EN skips the UIR phase when the IR matches the previous scan.
module jtag_debug_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int TCK_DIV    = 2,
  parameter int DR_WIDTH   = DEFAULT_DR_WIDTH,
  parameter int IR_WIDTH   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int BW = DR_WIDTH > 1 ? $clog2(DR_WIDTH) : 1;
  localparam int RW = RTI_CYCLES > 1 ? $clog2(RTI_CYCLES) : 1;
  state_t state, state_n;
  logic [DR_WIDTH-1:0] data_q;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] rti_cnt;
  logic tck_en, rise, fall, accept, ir_hit, last_bit, last_rti;
  assign tck_en   = state != S_IDLE && state != S_DONE;
  assign accept   = cmd_valid && state == S_IDLE;
  assign last_bit = bit_cnt == BW'(DR_WIDTH - 1);
  assign last_rti = rti_cnt == RW'(RTI_CYCLES - 1);
  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk       (clk),
    .reset     (reset),
    .en        (tck_en),
    .tck       (vji_tck),
    .rise_tick (rise),
    .fall_tick (fall)
  );
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
  logic valid_ir;
  // vji_ir_in already holds the IR of the last scan, so it doubles as last_ir
  assign ir_hit = valid_ir && cmd_ir == vji_ir_in;
  always_ff @(posedge clk) begin
    if (reset) valid_ir <= 1'b0;
    else if (accept) valid_ir <= 1'b1;
  end
`else
  assign ir_hit = 1'b0;
`endif
  assign cmd_ready = state == S_IDLE;
  assign rsp_valid = state == S_DONE;
  assign vji_uir   = state == S_UIR;
  assign vji_cdr   = state == S_CDR;
  assign vji_sdr   = state == S_SHIFT;
  assign vji_udr   = state == S_UDR;
  assign vji_rti   = state == S_RTI;
  assign vji_tdi   = state == S_SHIFT && data_q[bit_cnt];
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = cmd_valid ? (ir_hit ? S_CDR : S_UIR) : S_IDLE;
      S_UIR:   state_n = fall ? S_CDR : S_UIR;
      S_CDR:   state_n = fall ? S_SHIFT : S_CDR;
      S_SHIFT: state_n = fall && last_bit ? S_UDR : S_SHIFT;
      S_UDR:   state_n = fall ? S_RTI : S_UDR;
      S_RTI:   state_n = fall && last_rti ? S_DONE : S_RTI;
      S_DONE:  state_n = rsp_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      data_q     <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_ir_in  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_q    <= cmd_data;
        vji_ir_in <= cmd_ir;
      end
      bit_cnt <= state != S_SHIFT ? '0 : fall ? bit_cnt + BW'(1) : bit_cnt;
      rti_cnt <= state != S_RTI ? '0 : fall ? rti_cnt + RW'(1) : rti_cnt;
      if (rise && state == S_SHIFT) rsp_data[bit_cnt] <= vji_tdo;
      if (rise && state == S_UDR) rsp_ir_out <= vji_ir_out;
    end
  end
endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// tb_jtag_debug_scan_master: table-driven and randomized scans against a shift-register debug-module model.
module tb_jtag_debug_scan_master;
  localparam int DW = 38;
  localparam int IW = 2;
  localparam int TD = 2;
  localparam int RC = 2;
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0] cmd_ir = '0, rsp_ir_out, vji_ir_in, vji_ir_out = '0;
  logic [DW-1:0] cmd_data = '0, rsp_data;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  jtag_debug_scan_master #(.TCK_DIV(TD), .DR_WIDTH(DW), .IR_WIDTH(IW), .RTI_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // debug-module model: shift register feeding tdo, or a one-tck loopback of tdi
  logic [DW-1:0] sr = '0;
  logic lb_d = 1'b0;
  bit lb_mode = 1'b0;
  logic [IW-1:0] cur_ir = '0;
  int n_uir, n_cdr, n_sdr, n_udr, n_rti;
  logic tdi_seen[$];
  assign vji_tdo = lb_mode ? lb_d : sr[0];
  always @(posedge vji_tck) begin
    n_uir = n_uir + int'(vji_uir);
    n_cdr = n_cdr + int'(vji_cdr);
    n_sdr = n_sdr + int'(vji_sdr);
    n_udr = n_udr + int'(vji_udr);
    n_rti = n_rti + int'(vji_rti);
    if (vji_sdr) begin
      tdi_seen.push_back(vji_tdi);
      sr = sr >> 1;
    end
    lb_d = vji_tdi;
  end
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_onehot", 64'($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti})),
          (cmd_ready || rsp_valid) ? 64'd0 : 64'd1);
      if (vji_uir || vji_cdr || vji_sdr || vji_udr || vji_rti) chk("ir_in_during_scan", 64'(vji_ir_in), 64'(cur_ir));
    end
  end
  bit m_valid = 1'b0, exp_hit;
  logic [IW-1:0] m_last = '0;
  int lat;
  task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] data, input logic [DW-1:0] pre,
                      input logic [IW-1:0] irout, input bit lb);
    int t;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    tdi_seen.delete();
    sr = pre;
    lb_mode = lb;
    vji_ir_out = irout;
    cur_ir = ir;
    exp_hit = CACHE_EN && m_valid && ir == m_last;
    m_valid = 1'b1;
    m_last = ir;
    @(negedge clk);
    cmd_ir = ir;
    cmd_data = data;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
  endtask
  task automatic finish(input string nm, input logic [DW-1:0] data, input logic [DW-1:0] exp_rsp,
                        input logic [IW-1:0] exp_irout, input int hold);
    logic [DW-1:0] got, snap;
    while (!rsp_valid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(2 * TD * (3 + DW + RC) + 1 - (exp_hit ? 2 * TD : 0)));
    chk({nm, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    chk({nm, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(exp_irout));
    got = '0;
    foreach (tdi_seen[i]) if (i < DW) got[i] = tdi_seen[i];
    chk({nm, "_tdi_seq"}, 64'(got), 64'(data));
    chk({nm, "_uir_periods"}, 64'(n_uir), exp_hit ? 64'd0 : 64'd1);
    chk({nm, "_cdr_periods"}, 64'(n_cdr), 64'd1);
    chk({nm, "_sdr_periods"}, 64'(n_sdr), 64'(DW));
    chk({nm, "_udr_periods"}, 64'(n_udr), 64'd1);
    chk({nm, "_rti_periods"}, 64'(n_rti), 64'(RC));
    snap = rsp_data;
    if (hold > 0) begin
      cmd_ir = ~cur_ir;
      cmd_valid = 1'b1;
    end
    repeat (hold) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_hold_ready"}, 64'(cmd_ready), 64'd0);
      chk({nm, "_hold_data"}, 64'(rsp_data), 64'(snap));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({nm, "_idle_after_rsp"}, 64'({cmd_ready, rsp_valid}), 64'b10);
    chk({nm, "_ir_in_holds"}, 64'(vji_ir_in), 64'(cur_ir));
  endtask
  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] data;
    logic [DW-1:0] pre;
    logic [IW-1:0] irout;
    bit lb;
    logic [DW-1:0] exp_rsp;
  } vec_t;
  vec_t vecs[10];
  initial begin
    logic [DW-1:0] d;
    bit seen;
    int t;
    d = 38'h15_5555_5555;
    vecs[0] = '{2'd2, d, '0, 2'd1, 1'b1, {d[DW-2:0], 1'b0}};
    vecs[1] = '{2'd0, 38'h3F_0000_FFFF, 38'h2A_DEAD_BEEF, 2'd2, 1'b0, 38'h2A_DEAD_BEEF};
    vecs[2] = '{2'd3, 38'h00_0000_0001, 38'h20_0000_0000, 2'd3, 1'b0, 38'h20_0000_0000};
    vecs[3] = '{2'd3, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'd0, 1'b1, 38'h3F_FFFF_FFFE};
    for (int i = 4; i < 10; i++) begin
      d = DW'({$urandom(), $urandom()});
      vecs[i].ir = IW'($urandom_range(3, 0));
      vecs[i].data = DW'({$urandom(), $urandom()});
      vecs[i].pre = d;
      vecs[i].irout = IW'($urandom_range(3, 0));
      vecs[i].lb = 1'b0;
      vecs[i].exp_rsp = d;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}),
        64'b1_0000_0000);
    chk("reset_rsp", 64'({rsp_data, rsp_ir_out, vji_ir_in}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].ir, vecs[i].data, vecs[i].pre, vecs[i].irout, vecs[i].lb);
      finish($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_rsp, vecs[i].irout, i == 1 ? 20 : 0);
    end
    send(2'd1, 38'h12_3456_789A, 38'h0F_0F0F_0F0F, 2'd2, 1'b0);
    t = 0;
    while (n_sdr < 17 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_bit17", 64'(n_sdr), 64'd17);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_strobes", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
    chk("abort_handshake", 64'({cmd_ready, rsp_valid}), 64'b10);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("no_rsp_after_abort", 64'(seen), 64'd0);
    send(2'd1, 38'h0A_BCDE_F012, 38'h31_4159_2653, 2'd1, 1'b0);
    finish("after_abort", 38'h0A_BCDE_F012, 38'h31_4159_2653, 2'd1, 0);
    send(2'd1, 38'h01_0203_0405, 38'h05_0403_0201, 2'd3, 1'b0);
    finish("same_ir", 38'h01_0203_0405, 38'h05_0403_0201, 2'd3, 0);
    send(2'd3, 38'h2B_ADC0_FFEE, 38'h1C_0FFE_E123, 2'd0, 1'b0);
    finish("new_ir", 38'h2B_ADC0_FFEE, 38'h1C_0FFE_E123, 2'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
